// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge_if
// Description : Command/response stream and APB bus bundle for the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    // Bridge view
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    // Requester plus APB slave view
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : Valid/ready command stream to single APB3 transfers, with
//               address-range rejection and PREADY wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_LIMIT     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  wire logic         PCLK,
    input  wire logic         PRESET,
    apb_master_bridge_if.master bus
);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LIMIT = ADDR_WIDTH'(ADDR_LIMIT);
    localparam logic [CNT_WIDTH-1:0]  c_TIMEOUT    = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX    = '1;

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_write;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_cmd_ready;
    logic                  w_addr_ok;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_timeout;

    assign w_cmd_ready = (r_state == c_IDLE) & PRESET;
    assign w_addr_ok   = (bus.cmd_addr < c_ADDR_LIMIT);
    assign w_cnt_inc   = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    // Abort on the edge whose increment would bring the wait count to the limit
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (w_cnt_inc >= c_TIMEOUT);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.cmd_valid && w_cmd_ready) begin
                        r_rsp_write <= bus.cmd_write;
                        if (w_addr_ok) begin
                            r_paddr  <= bus.cmd_addr;
                            r_pwrite <= bus.cmd_write;
                            r_pwdata <= bus.cmd_wdata;
                            r_psel   <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= c_SETUP;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= c_RESP;
                        end
                    end
                end
                c_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= c_ACCESS;
                end
                c_ACCESS: begin
                    if (bus.PREADY) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
                        r_state     <= c_RESP;
                    end else if (w_timeout) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_cnt       <= w_cnt_inc;
                        r_state     <= c_RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_write = r_rsp_write;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PADDR     = r_paddr;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PWDATA    = r_pwdata;
endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Scoreboard bench for apb_master_bridge with a 32-word APB slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LIMIT(32),
        .TIMEOUT_CYCLES(16), .CNT_WIDTH(8)
    ) dut (
        .PCLK(clk),
        .PRESET(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic [31:0] cur_addr = '0;
    logic        cur_write = 1'b0;

    // Bench APB slave: zero-wait unless stalled, PREADY follows PSEL&PENABLE
    logic [31:0] mem [0:31];
    logic        stall = 1'b0;
    logic        init_mem = 1'b1;
    assign bus.PREADY = bus.PSEL & bus.PENABLE & ~stall;
    assign bus.PRDATA = mem[bus.PADDR[4:0]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 3) ? 32'hA5A5A5A5 : 32'h0;
        end else if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) begin
            mem[bus.PADDR[4:0]] <= bus.PWDATA;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor / scoreboard
    logic prev_valid = 1'b0;
    int   rise_cyc = 0;
    int   n_rise = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.rsp_valid && !prev_valid) begin
                rise_cyc = cyc;
                n_rise++;
            end
            prev_valid = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got rdata %0h err %0b expected none", bus.rsp_rdata, bus.rsp_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_fields", {bus.rsp_write, bus.rsp_rdata, bus.rsp_err},
                        {mon_e.wr, mon_e.rdata, mon_e.err});
                    chk("rsp_latency", 64'(rise_cyc - mon_e.acc), 64'(mon_e.lat));
                end
            end
        end
    end

    // APB protocol observer
    logic p_psel = 1'b0;
    logic p_pen = 1'b0;
    bit   have_prev = 1'b0;
    int   gap = 0;
    int   acc_run = 0;
    int   last_acc_len = 0;
    int   n_setups = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_psel = 1'b0; p_pen = 1'b0; have_prev = 1'b0; gap = 0; acc_run = 0;
        end else begin
            if (p_psel && !p_pen) chk("setup_to_access", {bus.PSEL, bus.PENABLE}, 2'b11);
            if (bus.PSEL && !bus.PENABLE) begin
                n_setups++;
                if (have_prev) chk("idle_gap_ge2", 64'(gap >= 2), 1);
                chk("setup_addr", bus.PADDR, cur_addr);
                chk("setup_write", bus.PWRITE, cur_write);
                have_prev = 1'b1;
            end
            if (bus.PSEL && bus.PENABLE) begin
                acc_run++;
                chk("access_addr_stable", bus.PADDR, cur_addr);
            end else if (acc_run != 0) begin
                last_acc_len = acc_run;
                acc_run = 0;
            end
            gap = bus.PSEL ? 0 : gap + 1;
            p_psel = bus.PSEL;
            p_pen = bus.PENABLE;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] erd, input logic eerr, input int lat, input bit keep);
        int   n = 0;
        exp_t ent;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
        @(negedge clk);
        while (!bus.cmd_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept: got cmd_ready 0 expected 1 within 200 cycles");
        end else begin
            ent.wr = wr; ent.rdata = erd; ent.err = eerr; ent.acc = cyc; ent.lat = lat;
            exp_q.push_back(ent);
            cur_addr  = addr;
            cur_write = wr;
            last_acc  = cyc;
        end
        @(posedge clk); #1;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_wait: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int snap;
        int prev_acc;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_psel", bus.PSEL, 0);
        chk("reset_penable", bus.PENABLE, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        chk("reset_cmd_ready", bus.cmd_ready, 0);
        chk("reset_paddr", bus.PADDR, 0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 0);
        @(posedge clk); #1;
        init_mem = 1'b0;
        rst_n = 1'b1;

        // Write then read
        send_cmd(1'b1, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b0);
        wait_done(50);
        send_cmd(1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
        wait_done(50);

        // Out of range
        snap = n_setups;
        send_cmd(1'b1, 32'd32, 32'h1234, 32'h0, 1'b1, 1, 1'b0);
        wait_done(50);
        chk("oor_no_psel", 64'(n_setups - snap), 0);
        send_cmd(1'b0, 32'd0, 32'h0, 32'h0, 1'b0, 3, 1'b0);
        wait_done(50);

        // Timeout
        stall = 1'b1;
        send_cmd(1'b1, 32'd7, 32'h77, 32'h0, 1'b1, 18, 1'b0);
        wait_done(100);
        chk("timeout_access_len", 64'(last_acc_len), 16);
        stall = 1'b0;
        send_cmd(1'b1, 32'd8, 32'h55, 32'h0, 1'b0, 3, 1'b0);
        wait_done(50);
        send_cmd(1'b0, 32'd8, 32'h0, 32'h55, 1'b0, 3, 1'b0);
        wait_done(50);
        send_cmd(1'b0, 32'd7, 32'h0, 32'h0, 1'b0, 3, 1'b0);
        wait_done(50);

        // Backpressure
        bus.rsp_ready = 1'b0;
        send_cmd(1'b0, 32'd3, 32'h0, 32'hA5A5A5A5, 1'b0, 3, 1'b0);
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'hA5A5A5A5);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
            chk("bp_psel", bus.PSEL, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_back_to_idle", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
        wait_done(10);

        // Stream of writes then reads
        prev_acc = 0;
        for (int i = 0; i < 32; i++) begin
            send_cmd(1'b1, 32'(i), 32'(i * 3), 32'h0, 1'b0, 3, i < 31);
            if (i > 0) chk("stream_wr_spacing", 64'(last_acc - prev_acc), 4);
            prev_acc = last_acc;
        end
        wait_done(50);
        for (int i = 0; i < 32; i++) begin
            send_cmd(1'b0, 32'(i), 32'h0, 32'(i * 3), 1'b0, 3, i < 31);
            if (i > 0) chk("stream_rd_spacing", 64'(last_acc - prev_acc), 4);
            prev_acc = last_acc;
        end
        wait_done(50);

        // Reset during ACCESS
        stall = 1'b1;
        send_cmd(1'b0, 32'd10, 32'h0, 32'd30, 1'b0, 3, 1'b0);
        n = 0;
        @(negedge clk);
        while (!(bus.PSEL && bus.PENABLE) && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("pre_reset_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_psel", bus.PSEL, 0);
        chk("async_rst_penable", bus.PENABLE, 0);
        chk("async_rst_rsp_valid", bus.rsp_valid, 0);
        chk("async_rst_cmd_ready", bus.cmd_ready, 0);
        exp_q.delete();
        stall = 1'b0;
        snap = n_rise;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", 64'(n_rise - snap), 0);
        chk("idle_after_reset", {bus.cmd_ready, bus.PSEL}, 2'b10);
        send_cmd(1'b0, 32'd10, 32'h0, 32'd30, 1'b0, 3, 1'b0);
        wait_done(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream requester for the team's APB memory slave. Converts a valid/ready command stream into single APB3-style transfers: PSEL/PENABLE/PADDR/PWRITE/PWDATA out, PRDATA/PREADY in.
- Returns one response per command on a valid/ready response channel.
- Adds two protections the slave does not provide:
  - address-range rejection;
  - a PREADY wait timeout.
- Forces an idle bus cycle between transfers so the slave FSM returns to IDLE.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of write and read data.
- ADDR_LIMIT, 32, number of valid word addresses; cmd_addr >= ADDR_LIMIT is rejected.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY=0 before abort. 0 disables the timeout.
- CNT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- PCLK  in  1  bus clock; all state updates on the rising edge.
- PRESET  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  word address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  1 = address rejected or timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset (PRESET=0, asynchronous): state=IDLE. PSEL, PENABLE, PWRITE, rsp_valid, rsp_write, rsp_err = 0. PADDR, PWDATA, rsp_rdata = 0. cmd_ready=0 while PRESET=0.
- All outputs are registered except cmd_ready = (state==IDLE) & PRESET.
- State machine (IDLE, SETUP, ACCESS, RESP):
  - IDLE: cmd_ready=1, PSEL=0, PENABLE=0.
    - On cmd_valid & cmd_ready, latch cmd_write, cmd_addr, cmd_wdata.
    - If cmd_addr < ADDR_LIMIT: go to SETUP, loading PADDR, PWRITE and PWDATA.
    - Otherwise: go to RESP with rsp_err=1, rsp_rdata=0, and no APB activity.
  - SETUP: PSEL=1, PENABLE=0, for exactly one cycle; then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA stay stable for the whole transfer.
    - At a rising edge with PREADY=1: go to RESP, rsp_err=0, rsp_rdata = PWRITE ? 0 : PRDATA (sampled at that edge).
    - Each edge with PREADY=0 increments the wait counter.
    - When the counter reaches TIMEOUT_CYCLES (if nonzero) with PREADY still 0: go to RESP, rsp_err=1, rsp_rdata=0.
  - RESP: PSEL=0, PENABLE=0, rsp_valid=1; response fields held stable. On rsp_valid & rsp_ready, go to IDLE and drop rsp_valid.
- Wait counter: cleared on entry to SETUP; saturates; no wrap.
- Bus spacing: RESP plus IDLE guarantee at least 2 cycles with PSEL=0 between transfers. The slave keeps PREADY high until it sees PSEL=0 & PENABLE=0, so back-to-back SETUP is forbidden.
- Minimum latency, rsp_ready held high:
  - accept edge → SETUP → ACCESS;
  - PREADY=1 at the first ACCESS edge → rsp_valid visible in the cycle after that edge;
  - command-to-response = 3 cycles;
  - peak rate = one transfer per 4 cycles.
- Rejected address: response after 1 cycle.
- Response backpressure: the bridge stalls in RESP indefinitely. cmd_ready stays 0 throughout, so at most one command is outstanding.
- PREADY outside ACCESS is ignored. PRDATA is sampled only at the completing edge.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously; the in-flight command is discarded with no response. After reset release, the first transfer is a clean SETUP.
- PWDATA on reads: holds cmd_wdata (don't-care to the slave), but it is driven deterministically.

Test Plan:
- Write then read: write addr 5 data 0xDEADBEEF, then read addr 5. Required:
  - PSEL=1,PENABLE=0 for 1 cycle, then PSEL=1,PENABLE=1;
  - write response rsp_err=0, rsp_rdata=0;
  - read response rsp_rdata=0xDEADBEEF, rsp_err=0;
  - PSEL=0 for ≥2 cycles between the transfers.
- Out of range: cmd_addr=32 write 0x1234. Required:
  - PSEL never asserts;
  - rsp_valid 1 cycle after accept with rsp_err=1, rsp_rdata=0;
  - a following read of addr 0 succeeds.
- Timeout: a bench slave holds PREADY=0. Required:
  - PSEL/PENABLE stay high for 16 ACCESS cycles, then drop;
  - response rsp_err=1, rsp_rdata=0;
  - a subsequent transfer completes normally.
- Backpressure: read addr 3 (preloaded 0xA5A5A5A5), rsp_ready=0 for 10 cycles. Required:
  - rsp_valid and rsp_rdata=0xA5A5A5A5 stable;
  - cmd_ready=0 and PSEL=0 for all 10 cycles;
  - on rsp_ready=1, the bridge returns to IDLE the next cycle.
- Stream: 32 back-to-back writes (addr i, data i*3) with cmd_valid held high, then 32 reads. Required:
  - every read returns i*3;
  - exactly 4 cycles per transfer with rsp_ready=1.
- Reset mid-ACCESS: assert PRESET=0 during ACCESS. Required:
  - PSEL, PENABLE and rsp_valid fall without waiting for a PCLK edge;
  - no response is produced after release;
  - a new read of a previously written address returns the correct data.
